rename_commit_ctrl: RTL and testbench

- Sequencer for the register renaming map.
- Gates new renames into the map's fetch_entry_ready_i.
- Tracks in-flight renamed instructions in an in-order queue, and the free physical register count.
- On in-order commit, drives the map's we_gp_i/waddr_i to deallocate the physical register the committing instruction displaced.
- Sits between the front end/issue stage and renaming_map. Also provides a drain FSM for quiescing the rename path.

---
 rtl/rename_commit_ctrl.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_rename_commit_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_commit_ctrl.sv
// -----------------------------------------------------------------------------
// rename_commit_ctrl
//
// Sequencer in front of renaming_map. It decides when a new rename may fire
// (rename_en_o drives the map's fetch_entry_ready_i). It keeps every renamed
// instruction in an in-order queue until it commits. On each commit it returns
// the physical register that the committing instruction displaced
// (dealloc_we_o/dealloc_addr_o drive the map's we_gp_i/waddr_i). A small FSM
// quiesces the rename path on request.
//
// Optional build macro: RENAME_COMMIT_CTRL_CHECK_EN
//   When defined, each queue entry also keeps alloc_phys, and a per-physical
//   register busy vector is maintained. Simulation assertions catch double
//   allocation, freeing a free register, commit while empty and free-count
//   under/overflow. Functional behaviour is identical either way.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   fetch_valid_i        front end presents an instruction
//   fetch_ready_o        controller accepts it this cycle
//   rd_arch_i            architectural destination (0 = no destination)
//   alloc_phys_i         physical register the map assigns this cycle
//   prev_phys_i          current mapping of rd_arch_i, freed at commit
//   rename_en_o          rename fires this cycle (combinational)
//   commit_valid_i       oldest in-flight instruction commits
//   commit_ready_o       queue is non-empty
//   dealloc_we_o         registered free strobe to the map
//   dealloc_addr_o       registered physical register being freed
//   drain_req_i          request to quiesce the rename path
//   drain_done_o         drained: everything in flight has committed
//   free_cnt_o           number of free physical registers
//   inflight_cnt_o       queue occupancy
// -----------------------------------------------------------------------------
module rename_commit_ctrl #(
   parameter int ARCH_REG_WIDTH = 5,
   parameter int PHYS_REG_WIDTH = 6,
   parameter int NR_INFLIGHT    = 8
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              fetch_valid_i,
   output logic                              fetch_ready_o,
   input  logic [ARCH_REG_WIDTH-1:0]         rd_arch_i,
   input  logic [PHYS_REG_WIDTH-1:0]         alloc_phys_i,
   input  logic [PHYS_REG_WIDTH-1:0]         prev_phys_i,
   output logic                              rename_en_o,
   input  logic                              commit_valid_i,
   output logic                              commit_ready_o,
   output logic                              dealloc_we_o,
   output logic [PHYS_REG_WIDTH-1:0]         dealloc_addr_o,
   input  logic                              drain_req_i,
   output logic                              drain_done_o,
   output logic [PHYS_REG_WIDTH:0]           free_cnt_o,
   output logic [$clog2(NR_INFLIGHT):0]      inflight_cnt_o
);

   localparam int NR_ARCH = 2 ** ARCH_REG_WIDTH;
   localparam int NR_PHYS = 2 ** PHYS_REG_WIDTH;
   localparam int PTR_W   = $clog2(NR_INFLIGHT);
   localparam int CNT_W   = PTR_W + 1;
   localparam int FREE_W  = PHYS_REG_WIDTH + 1;

   // Architectural registers start out mapped one-to-one onto the low
   // physical registers, so only the remainder is free after reset.
   localparam logic [FREE_W-1:0] FREE_RESET = FREE_W'(NR_PHYS - NR_ARCH);
   localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(NR_INFLIGHT);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      DRAINED = 2'd2
   } state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e                    state_q, state_d;
   logic [PTR_W-1:0]          head_q, head_d;
   logic [PTR_W-1:0]          tail_q, tail_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic [FREE_W-1:0]         free_cnt_q, free_cnt_d;
   logic                      dealloc_we_q, dealloc_we_d;
   logic [PHYS_REG_WIDTH-1:0] dealloc_addr_q, dealloc_addr_d;
   logic                      drain_done_q, drain_done_d;

   // In-flight queue storage, one entry per renamed instruction.
   logic                      q_has_rd_q [NR_INFLIGHT];
   logic [PHYS_REG_WIDTH-1:0] q_prev_q   [NR_INFLIGHT];

   // ---------------------------------------------------------------------------
   // Handshakes
   // ---------------------------------------------------------------------------
   logic writes_rd;
   logic empty;
   logic full;
   logic fetch_ready;
   logic rename_fire;
   logic commit_fire;
   logic head_has_rd;
   logic [PHYS_REG_WIDTH-1:0] head_prev;
   logic free_dec;
   logic free_inc;

   assign writes_rd   = (rd_arch_i != '0);
   assign empty       = (count_q == '0);
   assign full        = (count_q == CNT_FULL);

   // drain_req_i is folded in next to the state so that renames stop in the
   // very cycle the request is raised, not one cycle later when the state
   // register has moved to DRAIN. A full queue blocks fetch even while a
   // commit frees a slot in the same cycle, so commit_valid_i never reaches
   // this path.
   assign fetch_ready = (state_q == RUN) && !drain_req_i && !full &&
                        ((free_cnt_q != '0) || !writes_rd);

   assign rename_fire = fetch_valid_i && fetch_ready;
   assign commit_fire = commit_valid_i && !empty;

   assign head_has_rd = q_has_rd_q[head_q];
   assign head_prev   = q_prev_q[head_q];

   assign free_dec    = rename_fire && writes_rd;
   assign free_inc    = commit_fire && head_has_rd;

   // ---------------------------------------------------------------------------
   // Queue pointers, counters and dealloc port
   // ---------------------------------------------------------------------------
   // NOTE: every variable assigned in an always_comb gets a default first, so
   // no path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      free_cnt_d     = free_cnt_q;
      dealloc_we_d   = 1'b0;
      dealloc_addr_d = dealloc_addr_q;

      // Pointers are exactly PTR_W bits wide, so they wrap modulo the depth.
      if (rename_fire) tail_d = tail_q + 1'b1;
      if (commit_fire) head_d = head_q + 1'b1;

      unique case ({rename_fire, commit_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // A simultaneous allocate and free cancel out.
      if (free_dec && !free_inc) begin
         free_cnt_d = free_cnt_q - 1'b1;
      end else if (free_inc && !free_dec) begin
         free_cnt_d = free_cnt_q + 1'b1;
      end

      // The address follows every commit, even one without a destination,
      // and holds between commits; the strobe marks the real frees.
      if (commit_fire) begin
         dealloc_we_d   = head_has_rd;
         dealloc_addr_d = head_prev;
      end
   end

   // ---------------------------------------------------------------------------
   // Drain FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (drain_req_i) state_d = DRAIN;
         end
         DRAIN: begin
            // An early withdrawal wins over reaching empty.
            if (!drain_req_i) begin
               state_d = RUN;
            end else if (empty) begin
               state_d = DRAINED;
            end
         end
         DRAINED: begin
            if (!drain_req_i) state_d = RUN;
         end
         default: state_d = RUN;
      endcase

      drain_done_d = (state_d == DRAINED);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before the edge no matter the statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= RUN;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         free_cnt_q     <= FREE_RESET;
         dealloc_we_q   <= 1'b0;
         dealloc_addr_q <= '0;
         drain_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         free_cnt_q     <= free_cnt_d;
         dealloc_we_q   <= dealloc_we_d;
         dealloc_addr_q <= dealloc_addr_d;
         drain_done_q   <= drain_done_d;
      end
   end

   // NOTE: the queue storage is deliberately not reset. An entry is only read
   // once the occupancy counter says it was written, and clearing the
   // counter and pointers on reset discards all in-flight entries.
   always_ff @(posedge clk_i) begin
      if (rename_fire) begin
         q_has_rd_q[tail_q] <= writes_rd;
         q_prev_q[tail_q]   <= prev_phys_i;
      end
   end

   // ---------------------------------------------------------------------------
   // Optional consistency checker
   // ---------------------------------------------------------------------------
`ifdef RENAME_COMMIT_CTRL_CHECK_EN
   // The identity-mapped architectural registers are busy from reset.
   localparam logic [NR_PHYS-1:0] BUSY_RESET =
      {{(NR_PHYS - NR_ARCH){1'b0}}, {NR_ARCH{1'b1}}};

   logic [PHYS_REG_WIDTH-1:0] q_alloc_q [NR_INFLIGHT];
   logic [NR_PHYS-1:0]        busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      // Free before allocate: the map only sees the free one cycle later, so
      // it cannot hand the same register out again in this cycle.
      if (free_inc) busy_d[head_prev]    = 1'b0;
      if (free_dec) busy_d[alloc_phys_i] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= BUSY_RESET;
      end else begin
         busy_q <= busy_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rename_fire) begin
         q_alloc_q[tail_q] <= alloc_phys_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(free_dec && busy_q[alloc_phys_i]));
         assert (!(free_inc && !busy_q[head_prev]));
         // The register the committing instruction owns must still be live.
         assert (!(free_inc && !busy_q[q_alloc_q[head_q]]));
         assert (!(commit_valid_i && empty));
         assert (!(free_dec && !free_inc && (free_cnt_q == '0)));
         assert (!(free_inc && !free_dec && (free_cnt_q == FREE_RESET)));
      end
   end
`else
   // alloc_phys_i only feeds the checker; tie it off when the checker is out.
   logic unused_alloc_phys;
   assign unused_alloc_phys = ^alloc_phys_i;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign fetch_ready_o  = fetch_ready;
   assign rename_en_o    = rename_fire;
   assign commit_ready_o = !empty;
   assign dealloc_we_o   = dealloc_we_q;
   assign dealloc_addr_o = dealloc_addr_q;
   assign drain_done_o   = drain_done_q;
   assign free_cnt_o     = free_cnt_q;
   assign inflight_cnt_o = count_q;

endmodule

// File: tb/tb_rename_commit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rename_commit_ctrl
//
// Directed bench for rename_commit_ctrl. The instance "dut" uses the default
// depth of 8. The instance "dut64" uses a 64-entry queue, so that the free
// register pool can actually run dry. Inputs change 1 time unit after a
// rising edge, and outputs are sampled before the next edge.
// -----------------------------------------------------------------------------
module tb_rename_commit_ctrl;

   logic clk = 1'b0;
   logic rst_ni;

   always #5 clk = ~clk;

   // Default-depth instance.
   logic       fetch_valid, fetch_ready, rename_en;
   logic [4:0] rd_arch;
   logic [5:0] alloc_phys, prev_phys;
   logic       commit_valid, commit_ready;
   logic       dealloc_we;
   logic [5:0] dealloc_addr;
   logic       drain_req, drain_done;
   logic [6:0] free_cnt;
   logic [3:0] inflight_cnt;

   // 64-entry instance.
   logic       w_fetch_valid, w_fetch_ready, w_rename_en;
   logic [4:0] w_rd_arch;
   logic [5:0] w_alloc_phys, w_prev_phys;
   logic       w_commit_valid, w_commit_ready;
   logic       w_dealloc_we;
   logic [5:0] w_dealloc_addr;
   logic       w_drain_req, w_drain_done;
   logic [6:0] w_free_cnt;
   logic [6:0] w_inflight_cnt;

   rename_commit_ctrl dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .fetch_valid_i  (fetch_valid),
      .fetch_ready_o  (fetch_ready),
      .rd_arch_i      (rd_arch),
      .alloc_phys_i   (alloc_phys),
      .prev_phys_i    (prev_phys),
      .rename_en_o    (rename_en),
      .commit_valid_i (commit_valid),
      .commit_ready_o (commit_ready),
      .dealloc_we_o   (dealloc_we),
      .dealloc_addr_o (dealloc_addr),
      .drain_req_i    (drain_req),
      .drain_done_o   (drain_done),
      .free_cnt_o     (free_cnt),
      .inflight_cnt_o (inflight_cnt)
   );

   rename_commit_ctrl #(.NR_INFLIGHT(64)) dut64 (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .fetch_valid_i  (w_fetch_valid),
      .fetch_ready_o  (w_fetch_ready),
      .rd_arch_i      (w_rd_arch),
      .alloc_phys_i   (w_alloc_phys),
      .prev_phys_i    (w_prev_phys),
      .rename_en_o    (w_rename_en),
      .commit_valid_i (w_commit_valid),
      .commit_ready_o (w_commit_ready),
      .dealloc_we_o   (w_dealloc_we),
      .dealloc_addr_o (w_dealloc_addr),
      .drain_req_i    (w_drain_req),
      .drain_done_o   (w_drain_done),
      .free_cnt_o     (w_free_cnt),
      .inflight_cnt_o (w_inflight_cnt)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_ni         = 1'b0;
      fetch_valid    = 1'b0; rd_arch   = '0; alloc_phys   = '0; prev_phys   = '0;
      commit_valid   = 1'b0; drain_req = 1'b0;
      w_fetch_valid  = 1'b0; w_rd_arch = '0; w_alloc_phys = '0; w_prev_phys = '0;
      w_commit_valid = 1'b0; w_drain_req = 1'b0;

      repeat (2) @(posedge clk);
      #1 rst_ni = 1'b1;
      #1;

      // ---- reset state ----
      check("rst_free",         32'(free_cnt),     32);
      check("rst_inflight",     32'(inflight_cnt), 0);
      check("rst_fetch_ready",  32'(fetch_ready),  1);
      check("rst_commit_ready", 32'(commit_ready), 0);
      check("rst_dealloc_we",   32'(dealloc_we),   0);
      check("rst_dealloc_addr", 32'(dealloc_addr), 0);
      check("rst_drain_done",   32'(drain_done),   0);
      check("rst_w_free",       32'(w_free_cnt),   32);

      // ---- rename rd=9 (alloc 32, prev 9), then commit ----
      fetch_valid = 1'b1; rd_arch = 5'd9; alloc_phys = 6'd32; prev_phys = 6'd9;
      #1;
      check("r9_rename_en", 32'(rename_en), 1);
      tick();
      fetch_valid = 1'b0; rd_arch = '0;
      #1;
      check("r9_free",         32'(free_cnt),     31);
      check("r9_inflight",     32'(inflight_cnt), 1);
      check("r9_commit_ready", 32'(commit_ready), 1);
      check("r9_dealloc_idle", 32'(dealloc_we),   0);
      commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0;
      check("c9_free",     32'(free_cnt),     32);
      check("c9_inflight", 32'(inflight_cnt), 0);
      check("c9_we",       32'(dealloc_we),   1);
      check("c9_addr",     32'(dealloc_addr), 9);
      tick();
      check("c9_we_drop",  32'(dealloc_we),   0);
      check("c9_addr_hold", 32'(dealloc_addr), 9);

      // ---- rename rd=0, then commit: no free count change, no free pulse ----
      fetch_valid = 1'b1; rd_arch = 5'd0; alloc_phys = 6'd0; prev_phys = 6'd0;
      tick();
      fetch_valid = 1'b0;
      check("r0_free",     32'(free_cnt),     32);
      check("r0_inflight", 32'(inflight_cnt), 1);
      commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0;
      check("c0_we",       32'(dealloc_we),   0);
      check("c0_free",     32'(free_cnt),     32);
      check("c0_addr",     32'(dealloc_addr), 0);
      check("c0_inflight", 32'(inflight_cnt), 0);

      // ---- fill the 8-deep queue (pointers start at 2, so they wrap) ----
      for (int k = 1; k <= 8; k++) begin
         fetch_valid = 1'b1; rd_arch = 5'(k); prev_phys = 6'(10 + k); alloc_phys = 6'(32 + k);
         #1;
         check($sformatf("fill_ready_%0d", k), 32'(fetch_ready), 1);
         tick();
      end
      rd_arch = 5'd9; prev_phys = 6'd19; alloc_phys = 6'd41;
      #1;
      check("full_inflight",  32'(inflight_cnt), 8);
      check("full_free",      32'(free_cnt),     24);
      check("full_ready",     32'(fetch_ready),  0);
      check("full_rename_en", 32'(rename_en),    0);
      // Commit and fetch together: the full queue still rejects the fetch.
      commit_valid = 1'b1;
      #1;
      check("full_commit_ready", 32'(fetch_ready), 0);
      tick();
      commit_valid = 1'b0;
      #1;
      check("pop_inflight", 32'(inflight_cnt), 7);
      check("pop_free",     32'(free_cnt),     25);
      check("pop_we",       32'(dealloc_we),   1);
      check("pop_addr",     32'(dealloc_addr), 11);
      check("pop_ready",    32'(fetch_ready),  1);
      tick();
      fetch_valid = 1'b0;
      check("refill_inflight", 32'(inflight_cnt), 8);
      check("refill_free",     32'(free_cnt),     24);
      // Drain the queue; frees must come back in program order.
      for (int k = 2; k <= 9; k++) begin
         commit_valid = 1'b1;
         tick();
         check($sformatf("order_we_%0d", k),   32'(dealloc_we),   1);
         check($sformatf("order_addr_%0d", k), 32'(dealloc_addr), 10 + k);
      end
      commit_valid = 1'b0;
      check("empty_inflight",     32'(inflight_cnt), 0);
      check("empty_free",         32'(free_cnt),     32);
      check("empty_commit_ready", 32'(commit_ready), 0);

      // ---- commit while empty is ignored ----
      commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0;
      check("ign_inflight", 32'(inflight_cnt), 0);
      check("ign_free",     32'(free_cnt),     32);
      check("ign_we",       32'(dealloc_we),   0);

      // ---- drain with three in flight ----
      for (int k = 1; k <= 3; k++) begin
         fetch_valid = 1'b1; rd_arch = 5'(k); prev_phys = 6'(19 + k); alloc_phys = 6'(40 + k);
         tick();
      end
      fetch_valid = 1'b0; rd_arch = 5'd4;
      check("d3_inflight", 32'(inflight_cnt), 3);
      check("d3_free",     32'(free_cnt),     29);
      drain_req = 1'b1;
      #1;
      check("drain_req_blocks", 32'(fetch_ready), 0);
      tick();
      check("drain_done_early", 32'(drain_done),  0);
      check("drain_ready",      32'(fetch_ready), 0);
      for (int k = 1; k <= 3; k++) begin
         commit_valid = 1'b1;
         tick();
      end
      commit_valid = 1'b0;
      check("drain_empty",      32'(inflight_cnt), 0);
      check("drain_done_lag",   32'(drain_done),   0);
      check("drain_last_addr",  32'(dealloc_addr), 22);
      tick();
      check("drain_done",       32'(drain_done),  1);
      check("drained_ready",    32'(fetch_ready), 0);
      check("drained_free",     32'(free_cnt),    32);
      drain_req = 1'b0;
      #1;
      check("drained_release_ready", 32'(fetch_ready), 0);
      tick();
      check("run_done",  32'(drain_done),  0);
      check("run_ready", 32'(fetch_ready), 1);

      // ---- drain withdrawn before empty: back to RUN ----
      fetch_valid = 1'b1; rd_arch = 5'd1;
      tick();
      fetch_valid = 1'b0;
      drain_req = 1'b1;
      tick();
      check("abort_done",     32'(drain_done),   0);
      check("abort_blocked",  32'(fetch_ready),  0);
      check("abort_inflight", 32'(inflight_cnt), 1);
      drain_req = 1'b0;
      tick();
      check("abort_run_ready", 32'(fetch_ready), 1);
      check("abort_run_done",  32'(drain_done),  0);

      // ---- reset mid-drain ----
      fetch_valid = 1'b1; rd_arch = 5'd5; prev_phys = 6'd30;
      tick();
      fetch_valid = 1'b0;
      drain_req = 1'b1;
      tick();
      commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0;
      check("pre_rst_we",   32'(dealloc_we),   1);
      check("pre_rst_free", 32'(free_cnt),     31);
      rst_ni = 1'b0;
      #1;
      check("mid_rst_inflight",     32'(inflight_cnt), 0);
      check("mid_rst_free",         32'(free_cnt),     32);
      check("mid_rst_we",           32'(dealloc_we),   0);
      check("mid_rst_addr",         32'(dealloc_addr), 0);
      check("mid_rst_commit_ready", 32'(commit_ready), 0);
      check("mid_rst_done",         32'(drain_done),   0);
      drain_req = 1'b0;
      tick();
      rst_ni = 1'b1;
      #1;
      check("post_rst_ready", 32'(fetch_ready), 1);

      // ---- 64-deep: exhaust the free pool ----
      for (int k = 0; k < 32; k++) begin
         w_fetch_valid = 1'b1;
         w_rd_arch     = 5'((k % 31) + 1);
         w_prev_phys   = 6'((k % 31) + 1);
         w_alloc_phys  = 6'(32 + k);
         tick();
      end
      w_fetch_valid = 1'b0; w_rd_arch = 5'd5;
      #1;
      check("w_free_zero",    32'(w_free_cnt),     0);
      check("w_inflight_32",  32'(w_inflight_cnt), 32);
      check("w_ready_rd5",    32'(w_fetch_ready),  0);
      w_rd_arch = 5'd0;
      #1;
      check("w_ready_rd0",    32'(w_fetch_ready),  1);
      w_fetch_valid = 1'b1;
      tick();
      w_fetch_valid = 1'b0;
      check("w_rd0_inflight", 32'(w_inflight_cnt), 33);
      check("w_rd0_free",     32'(w_free_cnt),     0);
      w_commit_valid = 1'b1;
      tick();
      w_commit_valid = 1'b0;
      check("w_c1_free",     32'(w_free_cnt),     1);
      check("w_c1_inflight", 32'(w_inflight_cnt), 32);
      check("w_c1_we",       32'(w_dealloc_we),   1);
      check("w_c1_addr",     32'(w_dealloc_addr), 1);
      // Commit and rename together: the free count stays put.
      w_commit_valid = 1'b1; w_fetch_valid = 1'b1; w_rd_arch = 5'd7; w_prev_phys = 6'd7;
      #1;
      check("w_both_ready", 32'(w_fetch_ready), 1);
      tick();
      w_commit_valid = 1'b0; w_fetch_valid = 1'b0;
      check("w_both_free",     32'(w_free_cnt),     1);
      check("w_both_inflight", 32'(w_inflight_cnt), 32);
      check("w_both_addr",     32'(w_dealloc_addr), 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
